id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline register with load-use hazard detection for the 5-stage MIPS core. Sits between the decode stage (instruction decoder, register file read, immediate extender) and the execute stage. It registers the decoder's control word and operands, resolves the write-register address, and stalls decode for one cycle on a load-use hazard by inserting a bubble. It kills the decode-side instruction when execute redirects the PC.

## Interface
Parameters: none.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_valid` in 1: the decode-stage instruction is real (not a bubble).
- `id_LbOp`, `id_EqualOp`, `id_Branch`, `id_RegWrite`, `id_MemRead`, `id_MemWrite`, `id_ALUSrc1`, `id_ALUSrc2` in 1 each: decoder control bits.
- `id_PCSrc`, `id_RegDst`, `id_MemtoReg` in 2 each: decoder control fields.
- `id_rs`, `id_rt`, `id_rd`, `id_shamt` in 5 each: instruction fields.
- `id_rs_data`, `id_rt_data`, `id_imm_ext`, `id_pc_plus4` in 32 each: operands, extended immediate, and PC+4.
- `ex_flush` in 1: execute stage resolved a taken branch or a jump; kill the decode instruction.
- `hold` in 1: downstream freeze (memory wait); the whole register holds.
- `id_stall` out 1: combinational; freezes PC and IF/ID this cycle.
- `ex_*` out: registered copies of every `id_*` input above except `id_valid`, with matching widths.
- `ex_valid` out 1: registered valid.
- `ex_wr_addr` out 5: registered destination. RegDst 00 selects rt, 01 selects rd, 10 selects 31, 11 selects 0.
- Under `ID_EX_PERF_EN` only: `perf_stall_cnt` out 32 and `perf_flush_cnt` out 32.

## Operation
- Source usage, decided conservatively:
  - uses_rs = `!id_ALUSrc1 && id_PCSrc!=2'b01`
  - uses_rt = `(!id_ALUSrc2 || id_MemWrite) && id_PCSrc!=2'b01`
- hazard = `ex_valid && ex_MemRead && ex_wr_addr!=0 && id_valid && ((uses_rs && ex_wr_addr==id_rs) || (uses_rt && ex_wr_addr==id_rt))`.
- `id_stall` = `hazard && !ex_flush && !hold`.
- Next-state priority, per edge:
  1. `hold`: every register keeps its value.
  2. `ex_flush`: load a bubble.
  3. hazard: load a bubble.
  4. Otherwise: load the `id_*` inputs, with `ex_valid` set to `id_valid`.
- Bubble contents:
  - `ex_valid`, `ex_RegWrite`, `ex_MemRead`, `ex_MemWrite`, `ex_Branch` = 0; `ex_PCSrc` = 00.
  - All other fields = 0.
  - `ex_wr_addr` = 0.
- When `id_valid`=0, the inputs are loaded but all write/branch/PCSrc controls are forced to 0.
- No forwarding and no branch resolution in this block.

## Timing
- Latency is one cycle from decode inputs to `ex_*`.
- Reset value of every output register, including the counters: 0. Reset takes effect immediately on `rst_n` low, independent of `clk`.
- A load-use hazard stalls exactly one cycle. On the next edge the load moves on and the bubble sits in EX, so hazard is 0 (`ex_valid`=0).
- Simultaneous `ex_flush` and hazard: flush wins; `id_stall`=0, so IF/ID advances past the killed instruction.
- Simultaneous `hold` and `ex_flush`: hold wins. The execute stage keeps `ex_flush` asserted until `hold` drops, and that is a requirement on the driver. `id_stall`=0 during hold because the upstream freeze is driven separately.
- Reset mid-stall: `ex_valid`=0 at once, and `id_stall` falls combinationally.
- `ex_wr_addr`=0 never raises a hazard.

## Configuration
- Macro: `ID_EX_PERF_EN`.
- Defined:
  - `perf_stall_cnt` increments on every edge where `id_stall`=1.
  - `perf_flush_cnt` increments on every edge where `ex_flush`=1 and `hold`=0.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
  - Both reset to 0.
- Not defined: the counters and their ports are absent, with no other change.

## Test plan
- Reset: drive `rst_n`=0 asynchronously mid-cycle → all `ex_*`, `ex_valid`, and `ex_wr_addr` are 0 before the next edge; `id_stall`=0.
- Load-use: `lw $8,0($9)` then `add $10,$8,$11` → `id_stall`=1 for one cycle, a bubble is loaded (`ex_valid`=0, `ex_RegWrite`=0), then the add is loaded with `ex_wr_addr`=10.
- No false hazard:
  - `lw $0,0($9)` then `add $10,$0,$11` → `id_stall`=0.
  - `lw $8` then `ori $8,$12,1` (rt not a source) → `id_stall`=0.
- Flush priority: `ex_flush`=1 while a load-use hazard is present → `id_stall`=0, bubble loaded, `perf_flush_cnt` +1, `perf_stall_cnt` unchanged.
- Hold: `hold`=1 for 3 cycles with changing inputs → `ex_*` unchanged. With `ex_flush` held through the hold, a bubble is loaded on the first edge after `hold` drops.
- Jal destination: `id_RegDst`=10, `id_RegWrite`=1, `id_MemtoReg`=10 → `ex_wr_addr`=31; `ex_PCSrc`=01 passed through.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and flush.
// Optional performance counters are compiled in when ID_EX_PERF_EN is defined.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic        id_LbOp,
  input  logic        id_EqualOp,
  input  logic        id_Branch,
  input  logic        id_RegWrite,
  input  logic        id_MemRead,
  input  logic        id_MemWrite,
  input  logic        id_ALUSrc1,
  input  logic        id_ALUSrc2,
  input  logic [1:0]  id_PCSrc,
  input  logic [1:0]  id_RegDst,
  input  logic [1:0]  id_MemtoReg,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [4:0]  id_shamt,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm_ext,
  input  logic [31:0] id_pc_plus4,
  input  logic        ex_flush,
  input  logic        hold,
  output logic        id_stall,
  output logic        ex_LbOp,
  output logic        ex_EqualOp,
  output logic        ex_Branch,
  output logic        ex_RegWrite,
  output logic        ex_MemRead,
  output logic        ex_MemWrite,
  output logic        ex_ALUSrc1,
  output logic        ex_ALUSrc2,
  output logic [1:0]  ex_PCSrc,
  output logic [1:0]  ex_RegDst,
  output logic [1:0]  ex_MemtoReg,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_shamt,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm_ext,
  output logic [31:0] ex_pc_plus4,
  output logic        ex_valid,
  output logic [4:0]  ex_wr_addr
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef struct packed {
    logic        valid;
    logic        lbOp;
    logic        equalOp;
    logic        branch;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        aluSrc1;
    logic        aluSrc2;
    logic [1:0]  pcSrc;
    logic [1:0]  regDst;
    logic [1:0]  memtoReg;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] immExt;
    logic [31:0] pcPlus4;
    logic [4:0]  wrAddr;
  } exWord_t;

  localparam int unsigned WordW = $bits(exWord_t);
  localparam exWord_t Bubble = exWord_t'({WordW{1'b0}});

  exWord_t exWord_r;
  exWord_t loadWord_s;
  exWord_t nextWord_s;
  logic    usesRs_s;
  logic    usesRt_s;
  logic    hazard_s;

  // Load-use hazard detection against the load currently sitting in EX.
  always_comb begin
    usesRs_s = !id_ALUSrc1 && (id_PCSrc != 2'b01);
    usesRt_s = (!id_ALUSrc2 || id_MemWrite) && (id_PCSrc != 2'b01);
    hazard_s = exWord_r.valid && exWord_r.memRead && (exWord_r.wrAddr != 5'd0) && id_valid &&
               ((usesRs_s && (exWord_r.wrAddr == id_rs)) || (usesRt_s && (exWord_r.wrAddr == id_rt)));
    id_stall = hazard_s && !ex_flush && !hold;
  end

  // Assemble the decode word; a non-valid slot keeps operands but drops all side effects.
  always_comb begin
    loadWord_s          = Bubble;
    loadWord_s.valid    = id_valid;
    loadWord_s.lbOp     = id_LbOp;
    loadWord_s.equalOp  = id_EqualOp;
    loadWord_s.memRead  = id_MemRead;
    loadWord_s.aluSrc1  = id_ALUSrc1;
    loadWord_s.aluSrc2  = id_ALUSrc2;
    loadWord_s.regDst   = id_RegDst;
    loadWord_s.memtoReg = id_MemtoReg;
    loadWord_s.rs       = id_rs;
    loadWord_s.rt       = id_rt;
    loadWord_s.rd       = id_rd;
    loadWord_s.shamt    = id_shamt;
    loadWord_s.rsData   = id_rs_data;
    loadWord_s.rtData   = id_rt_data;
    loadWord_s.immExt   = id_imm_ext;
    loadWord_s.pcPlus4  = id_pc_plus4;
    if (id_valid) begin
      loadWord_s.branch   = id_Branch;
      loadWord_s.regWrite = id_RegWrite;
      loadWord_s.memWrite = id_MemWrite;
      loadWord_s.pcSrc    = id_PCSrc;
    end else begin
      loadWord_s.branch   = 1'b0;
      loadWord_s.regWrite = 1'b0;
      loadWord_s.memWrite = 1'b0;
      loadWord_s.pcSrc    = 2'b00;
    end
    case (id_RegDst)
      2'b00:   loadWord_s.wrAddr = id_rt;
      2'b01:   loadWord_s.wrAddr = id_rd;
      2'b10:   loadWord_s.wrAddr = 5'd31;
      2'b11:   loadWord_s.wrAddr = 5'd0;
      default: loadWord_s.wrAddr = 5'd0;
    endcase
  end

  // Next-state priority: hold, then flush, then hazard bubble, then normal load.
  always_comb begin
    nextWord_s = exWord_r;
    if (hold) begin
      nextWord_s = exWord_r;
    end else if (ex_flush || hazard_s) begin
      nextWord_s = Bubble;
    end else begin
      nextWord_s = loadWord_s;
    end
  end

  // Pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exWord_r <= Bubble;
    end else begin
      exWord_r <= nextWord_s;
    end
  end

  assign ex_valid    = exWord_r.valid;
  assign ex_LbOp     = exWord_r.lbOp;
  assign ex_EqualOp  = exWord_r.equalOp;
  assign ex_Branch   = exWord_r.branch;
  assign ex_RegWrite = exWord_r.regWrite;
  assign ex_MemRead  = exWord_r.memRead;
  assign ex_MemWrite = exWord_r.memWrite;
  assign ex_ALUSrc1  = exWord_r.aluSrc1;
  assign ex_ALUSrc2  = exWord_r.aluSrc2;
  assign ex_PCSrc    = exWord_r.pcSrc;
  assign ex_RegDst   = exWord_r.regDst;
  assign ex_MemtoReg = exWord_r.memtoReg;
  assign ex_rs       = exWord_r.rs;
  assign ex_rt       = exWord_r.rt;
  assign ex_rd       = exWord_r.rd;
  assign ex_shamt    = exWord_r.shamt;
  assign ex_rs_data  = exWord_r.rsData;
  assign ex_rt_data  = exWord_r.rtData;
  assign ex_imm_ext  = exWord_r.immExt;
  assign ex_pc_plus4 = exWord_r.pcPlus4;
  assign ex_wr_addr  = exWord_r.wrAddr;

`ifdef ID_EX_PERF_EN
  // Stall and flush event counters; wrap naturally at 32 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (id_stall) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end else begin
        perf_stall_cnt <= perf_stall_cnt;
      end
      if (ex_flush && !hold) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end else begin
        perf_flush_cnt <= perf_flush_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (counter checks active when ID_EX_PERF_EN is defined).
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_LbOp, id_EqualOp, id_Branch, id_RegWrite, id_MemRead, id_MemWrite;
  logic        id_ALUSrc1, id_ALUSrc2;
  logic [1:0]  id_PCSrc, id_RegDst, id_MemtoReg;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [31:0] id_rs_data, id_rt_data, id_imm_ext, id_pc_plus4;
  logic        ex_flush, hold, id_stall;
  logic        ex_LbOp, ex_EqualOp, ex_Branch, ex_RegWrite, ex_MemRead, ex_MemWrite;
  logic        ex_ALUSrc1, ex_ALUSrc2, ex_valid;
  logic [1:0]  ex_PCSrc, ex_RegDst, ex_MemtoReg;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt, ex_wr_addr;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm_ext, ex_pc_plus4;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int checkCount = 0;
  int errorCount = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_LbOp(id_LbOp), .id_EqualOp(id_EqualOp),
    .id_Branch(id_Branch), .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_ALUSrc1(id_ALUSrc1), .id_ALUSrc2(id_ALUSrc2), .id_PCSrc(id_PCSrc), .id_RegDst(id_RegDst),
    .id_MemtoReg(id_MemtoReg), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm_ext(id_imm_ext), .id_pc_plus4(id_pc_plus4),
    .ex_flush(ex_flush), .hold(hold), .id_stall(id_stall), .ex_LbOp(ex_LbOp), .ex_EqualOp(ex_EqualOp),
    .ex_Branch(ex_Branch), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_ALUSrc1(ex_ALUSrc1), .ex_ALUSrc2(ex_ALUSrc2), .ex_PCSrc(ex_PCSrc), .ex_RegDst(ex_RegDst),
    .ex_MemtoReg(ex_MemtoReg), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_shamt(ex_shamt),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext), .ex_pc_plus4(ex_pc_plus4),
    .ex_valid(ex_valid), .ex_wr_addr(ex_wr_addr)
`ifdef ID_EX_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    id_valid = 1'b0; id_LbOp = 1'b0; id_EqualOp = 1'b0; id_Branch = 1'b0; id_RegWrite = 1'b0;
    id_MemRead = 1'b0; id_MemWrite = 1'b0; id_ALUSrc1 = 1'b0; id_ALUSrc2 = 1'b0;
    id_PCSrc = 2'b00; id_RegDst = 2'b00; id_MemtoReg = 2'b00;
    id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_shamt = 5'd0;
    id_rs_data = 32'd0; id_rt_data = 32'd0; id_imm_ext = 32'd0; id_pc_plus4 = 32'd0;
  endtask

  // lw $rt, 0($rs)
  task automatic setLw(input logic [4:0] rt, input logic [4:0] rs);
    clearInputs();
    id_valid = 1'b1; id_RegWrite = 1'b1; id_MemRead = 1'b1; id_ALUSrc2 = 1'b1;
    id_MemtoReg = 2'b01; id_rs = rs; id_rt = rt; id_rs_data = 32'h0000_1000;
  endtask

  // add $rd, $rs, $rt
  task automatic setAdd(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rsData);
    clearInputs();
    id_valid = 1'b1; id_RegWrite = 1'b1; id_RegDst = 2'b01;
    id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsData; id_rt_data = 32'h0000_0022;
  endtask

  // ori $rt, $rs, 1
  task automatic setOri(input logic [4:0] rt, input logic [4:0] rs);
    clearInputs();
    id_valid = 1'b1; id_RegWrite = 1'b1; id_ALUSrc2 = 1'b1; id_rs = rs; id_rt = rt; id_imm_ext = 32'd1;
  endtask

  initial begin
    clearInputs();
    ex_flush = 1'b0; hold = 1'b0; rst_n = 1'b0;
    #3;
    checkVal("rst_valid", {31'd0, ex_valid}, 32'd0);
    checkVal("rst_wr_addr", {27'd0, ex_wr_addr}, 32'd0);
    checkVal("rst_stall", {31'd0, id_stall}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Load-use: lw $8,0($9) ; add $10,$8,$11
    setLw(5'd8, 5'd9);
    @(posedge clk); #1;
    checkVal("lw_wr_addr", {27'd0, ex_wr_addr}, 32'd8);
    checkVal("lw_memread", {31'd0, ex_MemRead}, 32'd1);
    @(negedge clk); setAdd(5'd10, 5'd8, 5'd11, 32'h0000_AAAA); #1;
    checkVal("lu_stall", {31'd0, id_stall}, 32'd1);
    @(posedge clk); #1;
    checkVal("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    checkVal("lu_bubble_regwrite", {31'd0, ex_RegWrite}, 32'd0);
    checkVal("lu_bubble_wr_addr", {27'd0, ex_wr_addr}, 32'd0);
    checkVal("lu_stall_released", {31'd0, id_stall}, 32'd0);
    @(posedge clk); #1;
    checkVal("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    checkVal("lu_add_wr_addr", {27'd0, ex_wr_addr}, 32'd10);
    checkVal("lu_add_rs_data", ex_rs_data, 32'h0000_AAAA);

    // No false hazard through $0
    @(negedge clk); setLw(5'd0, 5'd9);
    @(negedge clk); setAdd(5'd10, 5'd0, 5'd11, 32'd5); #1;
    checkVal("zero_no_stall", {31'd0, id_stall}, 32'd0);
    @(posedge clk); #1;
    checkVal("zero_add_valid", {31'd0, ex_valid}, 32'd1);

    // No false hazard when rt is a destination only
    @(negedge clk); setLw(5'd8, 5'd9);
    @(negedge clk); setOri(5'd8, 5'd12); #1;
    checkVal("ori_no_stall", {31'd0, id_stall}, 32'd0);
    @(posedge clk); #1;
    checkVal("ori_wr_addr", {27'd0, ex_wr_addr}, 32'd8);
    checkVal("ori_imm", ex_imm_ext, 32'd1);

    // Flush beats a load-use hazard
    @(negedge clk); setLw(5'd8, 5'd9);
    @(negedge clk); setAdd(5'd10, 5'd8, 5'd11, 32'd7); ex_flush = 1'b1; #1;
    checkVal("flush_no_stall", {31'd0, id_stall}, 32'd0);
    @(posedge clk); #1;
    checkVal("flush_bubble_valid", {31'd0, ex_valid}, 32'd0);
    checkVal("flush_bubble_rs_data", ex_rs_data, 32'd0);

    // Hold for three cycles with changing inputs and flush pending
    @(negedge clk); ex_flush = 1'b0; setAdd(5'd10, 5'd1, 5'd2, 32'hCAFE_0001);
    @(posedge clk); #1;
    checkVal("pre_hold_wr_addr", {27'd0, ex_wr_addr}, 32'd10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hold = 1'b1; ex_flush = 1'b1;
      setAdd(5'd5, 5'd3, 5'd4, 32'h1111_0000 + 32'(i));
      #1;
      checkVal("hold_stall", {31'd0, id_stall}, 32'd0);
      @(posedge clk); #1;
      checkVal("hold_wr_addr", {27'd0, ex_wr_addr}, 32'd10);
      checkVal("hold_rs_data", ex_rs_data, 32'hCAFE_0001);
      checkVal("hold_valid", {31'd0, ex_valid}, 32'd1);
    end
    @(negedge clk); hold = 1'b0;
    @(posedge clk); #1;
    checkVal("post_hold_bubble", {31'd0, ex_valid}, 32'd0);
    checkVal("post_hold_rs_data", ex_rs_data, 32'd0);
    @(negedge clk); ex_flush = 1'b0;

    // jal destination
    clearInputs();
    id_valid = 1'b1; id_RegDst = 2'b10; id_RegWrite = 1'b1; id_MemtoReg = 2'b10;
    id_PCSrc = 2'b01; id_pc_plus4 = 32'h0040_0010;
    @(posedge clk); #1;
    checkVal("jal_wr_addr", {27'd0, ex_wr_addr}, 32'd31);
    checkVal("jal_pcsrc", {30'd0, ex_PCSrc}, 32'd1);
    checkVal("jal_memtoreg", {30'd0, ex_MemtoReg}, 32'd2);
    checkVal("jal_pc_plus4", ex_pc_plus4, 32'h0040_0010);

    // RegDst 11 gives 0; an invalid slot drops write and branch controls
    @(negedge clk); setAdd(5'd9, 5'd1, 5'd2, 32'h0BAD_F00D);
    id_RegDst = 2'b11; id_valid = 1'b0; id_Branch = 1'b1; id_PCSrc = 2'b10;
    @(posedge clk); #1;
    checkVal("inv_wr_addr", {27'd0, ex_wr_addr}, 32'd0);
    checkVal("inv_regwrite", {31'd0, ex_RegWrite}, 32'd0);
    checkVal("inv_branch", {31'd0, ex_Branch}, 32'd0);
    checkVal("inv_pcsrc", {30'd0, ex_PCSrc}, 32'd0);
    checkVal("inv_rs_data", ex_rs_data, 32'h0BAD_F00D);

`ifdef ID_EX_PERF_EN
    checkVal("perf_stall", perf_stall_cnt, 32'd1);
    checkVal("perf_flush", perf_flush_cnt, 32'd2);
`endif

    // Asynchronous reset in the middle of a stall
    @(negedge clk); setLw(5'd8, 5'd9);
    @(negedge clk); setAdd(5'd10, 5'd8, 5'd11, 32'd3); #1;
    checkVal("mid_stall", {31'd0, id_stall}, 32'd1);
    #1; rst_n = 1'b0; #1;
    checkVal("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
    checkVal("mid_rst_memread", {31'd0, ex_MemRead}, 32'd0);
    checkVal("mid_rst_wr_addr", {27'd0, ex_wr_addr}, 32'd0);
    checkVal("mid_rst_stall", {31'd0, id_stall}, 32'd0);
`ifdef ID_EX_PERF_EN
    checkVal("mid_rst_perf_stall", perf_stall_cnt, 32'd0);
    checkVal("mid_rst_perf_flush", perf_flush_cnt, 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checkVal("after_rst_wr_addr", {27'd0, ex_wr_addr}, 32'd10);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
